// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode constants, the NOP word and the fetch state enum.
// Used by fetch_stage and fetch_pc_sel (optional early-jump feature: FETCH_JUMP_EN).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // J-type target: upper nibble of the sequential PC plus the word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch stage: redirect, hold, sequential, or (with
// FETCH_JUMP_EN defined) an early J-type target taken straight from the fetched word.
module fetch_pc_sel
    import mips_pkg::*;
(
    input  logic        fetch_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    input  logic        imem_rdy_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] pc_next_o
);

    logic [31:0] seq_pc;
    logic [31:0] adv_pc;

    assign seq_pc     = pc_i + 32'd4;
    assign pc_plus4_o = seq_pc;

`ifdef FETCH_JUMP_EN
    assign adv_pc = (instr_i[31:26] == OP_J) ? jump_target(seq_pc, instr_i) : seq_pc;
`else
    logic unused_instr;
    assign unused_instr = ^instr_i;
    assign adv_pc       = seq_pc;
`endif

    always_comb begin
        pc_next_o = pc_i;
        if (fetch_i) begin
            if (redirect_i)
                pc_next_o = {redirect_pc_i[31:2], 2'b00};
            else if (stall_i && imem_rdy_i)
                pc_next_o = adv_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC register, imem request and the IF/ID register (IRD/pcD).
// Defining FETCH_JUMP_EN lets accepted J-type words steer the PC without waiting for redirect.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IRD,
    output logic [31:0] pcD
);

    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ird_q, ird_d;
    logic [31:0]  pcd_q, pcd_d;
    logic [31:0]  pc_plus4;

    fetch_pc_sel u_pc_sel (
        .fetch_i       (state_q == FETCH),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .imem_rdy_i    (imem_rdy),
        .pc_i          (pc_q),
        .instr_i       (imem_rdata),
        .pc_plus4_o    (pc_plus4),
        .pc_next_o     (pc_d)
    );

    // stall is active-low: 0 freezes IF/ID and re-requests the same address.
    always_comb begin
        ird_d = ird_q;
        pcd_d = pcd_q;
        if (state_q == BOOT || redirect) begin
            ird_d = NOP_WORD;
            pcd_d = 32'd0;
        end else if (stall) begin
            if (imem_rdy) begin
                ird_d = imem_rdata;
                pcd_d = pc_plus4;
            end else begin
                ird_d = NOP_WORD;
                pcd_d = 32'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ird_q   <= NOP_WORD;
            pcd_q   <= 32'd0;
        end else begin
            state_q <= FETCH;
            pc_q    <= pc_d;
            ird_q   <= ird_d;
            pcd_q   <= pcd_d;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign IRD       = ird_q;
    assign pcD       = pcd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: rule-level model compared every cycle plus
// literal expectations for the boot, stall, redirect, bubble, wrap and jump scenarios.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall, redirect, imem_rdy;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata, IRD, pcD;

    logic        use_mem;
    logic [31:0] rdata_drv;

    int n_chk  = 0;
    int n_fail = 0;

    bit          m_fetch;
    logic [31:0] m_pc, m_ird, m_pcd;

`ifdef FETCH_JUMP_EN
    localparam logic [31:0] JMP_EXP = 32'h0000_0100;
`else
    localparam logic [31:0] JMP_EXP = 32'h0000_0014;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 ^ a;
    endfunction

    assign imem_rdata = use_mem ? mem_word(imem_addr) : rdata_drv;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_rdata  (imem_rdata),
        .IRD         (IRD),
        .pcD         (pcD)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = 1'b0;
        m_pc    = 32'h0;
        m_ird   = 32'h0;
        m_pcd   = 32'h0;
    endtask

    // What one clock edge must do, stated from the fetch rules.
    task automatic model_edge();
        logic [31:0] word;
        logic [31:0] nxt;
        word = use_mem ? mem_word(m_pc) : rdata_drv;
        if (!m_fetch) begin
            m_fetch = 1'b1;
            m_ird   = 32'h0;
            m_pcd   = 32'h0;
        end else if (redirect) begin
            m_pc  = redirect_pc & 32'hFFFF_FFFC;
            m_ird = 32'h0;
            m_pcd = 32'h0;
        end else if (stall) begin
            if (imem_rdy) begin
                nxt   = m_pc + 32'd4;
                m_ird = word;
                m_pcd = nxt;
`ifdef FETCH_JUMP_EN
                if (word[31:26] == 6'd2) nxt = {nxt[31:28], word[25:0], 2'b00};
`endif
                m_pc = nxt;
            end else begin
                m_ird = 32'h0;
                m_pcd = 32'h0;
            end
        end
    endtask

    task automatic cmp();
        check("req",  {31'd0, imem_req}, {31'd0, m_fetch});
        check("addr", imem_addr, m_pc);
        check("IRD",  IRD, m_ird);
        check("pcD",  pcD, m_pcd);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        cmp();
    endtask

    initial begin
        stall = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_rdy = 1'b1;
        use_mem = 1'b1; rdata_drv = 32'h0;
        rst = 1'b1;
        model_reset();
        #2;
        cmp();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_req", {31'd0, imem_req}, 32'd0);

        step();
        check("f0_addr", imem_addr, 32'h0);
        check("f0_req", {31'd0, imem_req}, 32'd1);
        step();
        check("f1_IRD", IRD, 32'h2000_0000); check("f1_pcD", pcD, 32'd4); check("f1_addr", imem_addr, 32'd4);
        step();
        check("f2_IRD", IRD, 32'h2000_0004); check("f2_pcD", pcD, 32'd8); check("f2_addr", imem_addr, 32'd8);
        step();
        check("f3_IRD", IRD, 32'h2000_0008); check("f3_pcD", pcD, 32'd12);

        // Hold IF/ID for three cycles.
        use_mem = 1'b0; rdata_drv = 32'h8C22_0004;
        step();
        check("ld_IRD", IRD, 32'h8C22_0004); check("ld_addr", imem_addr, 32'd16);
        stall = 1'b0; rdata_drv = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_IRD", IRD, 32'h8C22_0004);
            check("hold_pcD", pcD, 32'd16);
            check("hold_addr", imem_addr, 32'd16);
        end
        stall = 1'b1; use_mem = 1'b1;
        step();
        check("resume_IRD", IRD, 32'h2000_0010); check("resume_pcD", pcD, 32'd20);

        // Redirect wins over the hold.
        redirect = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b0;
        step();
        check("rd_IRD", IRD, 32'h0); check("rd_pcD", pcD, 32'h0); check("rd_addr", imem_addr, 32'h100);
        redirect = 1'b0; stall = 1'b1;

        // Two not-ready cycles produce bubbles.
        imem_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("bub_IRD", IRD, 32'h0);
            check("bub_addr", imem_addr, 32'h100);
        end
        imem_rdy = 1'b1;
        step();
        check("rdy_IRD", IRD, 32'h2000_0100); check("rdy_pcD", pcD, 32'h104);

        // PC wraps.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        check("wrap_pc", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        check("wrap_pcD", pcD, 32'h0); check("wrap_addr", imem_addr, 32'h0);
        check("wrap_IRD", IRD, 32'hDFFF_FFFC);

        // J-type word fetched at 0x10.
        redirect = 1'b1; redirect_pc = 32'h0000_0010;
        step();
        redirect = 1'b0; use_mem = 1'b0; rdata_drv = 32'h0800_0040;
        step();
        check("j_IRD", IRD, 32'h0800_0040); check("j_pcD", pcD, 32'h14); check("j_addr", imem_addr, JMP_EXP);

        // Redirect beats an early jump in the same cycle.
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        check("rj_addr", imem_addr, 32'h200); check("rj_IRD", IRD, 32'h0);
        redirect = 1'b0; use_mem = 1'b1;
        step();
        check("pre_IRD", IRD, 32'h2000_0200);

        // Reset while a request is pending.
        imem_rdy = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("ar_IRD", IRD, 32'h0); check("ar_pcD", pcD, 32'h0);
        check("ar_addr", imem_addr, 32'h0); check("ar_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0; imem_rdy = 1'b1;
        #1;
        check("ar_boot_req", {31'd0, imem_req}, 32'd0);
        step();
        check("ar_f0_addr", imem_addr, 32'h0);
        step();
        check("ar_f1_IRD", IRD, 32'h2000_0000); check("ar_f1_pcD", pcD, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
